// File: rtl/product_display_sequencer.sv
// Signed 8-bit product to three-digit seven-segment display sequencer.
// Shares one external hex decoder across the low and high magnitude nibbles.
module product_display_sequencer #(
    parameter bit         BLANK_LEADING = 1'b1,
    parameter logic [0:6] SIGN_PATTERN  = 7'b0000001
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOAD,
    input  logic [7:0] PRODUCT,
    output logic [3:0] NIB,
    input  logic [0:6] SEV_IN,
    output logic [0:6] HEX0,
    output logic [0:6] HEX1,
    output logic [0:6] HEX2,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        DEC_LO,
        DEC_HI,
        SIGN
    } state_t;

    state_t     state;
    logic [7:0] prod_q;
    logic [7:0] mag_q;
    logic       neg_q;
    logic [7:0] mag_c;
    logic       blank_hi;

    // Two's-complement magnitude; 8'h80 maps to 8'h80 as an unsigned value
    always_comb begin
        mag_c = prod_q;
        if (prod_q[7]) begin
            mag_c = ~prod_q + 8'd1;
        end
    end

    // Leading-digit blanking decision for the high nibble
    always_comb begin
        blank_hi = BLANK_LEADING && (mag_q[7:4] == 4'd0);
    end

    // Sequencer: capture, convert, decode low, decode high, sign
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            prod_q <= 8'd0;
            mag_q  <= 8'd0;
            neg_q  <= 1'b0;
            NIB    <= 4'd0;
            HEX0   <= 7'b0000000;
            HEX1   <= 7'b0000000;
            HEX2   <= 7'b0000000;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    NIB  <= 4'd0;
                    DONE <= 1'b0;
                    if (LOAD) begin
                        prod_q <= PRODUCT;
                        BUSY   <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    neg_q <= prod_q[7];
                    mag_q <= mag_c;
                    NIB   <= mag_c[3:0];
                    state <= DEC_LO;
                end
                DEC_LO: begin
                    HEX0  <= SEV_IN;
                    NIB   <= mag_q[7:4];
                    state <= DEC_HI;
                end
                DEC_HI: begin
                    HEX1  <= blank_hi ? 7'b0000000 : SEV_IN;
                    NIB   <= 4'd0;
                    DONE  <= 1'b1;
                    state <= SIGN;
                end
                SIGN: begin
                    HEX2  <= neg_q ? SIGN_PATTERN : 7'b0000000;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_display_sequencer.sv
// Bench for product_display_sequencer: two instances (blanking on/off)
// driven together, checked every cycle against a timestamp-based model.
module tb_product_display_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] prod = 8'd0;

    logic [3:0] nib1, nib0;
    logic [0:6] sev1, sev0;
    logic [0:6] h0a, h1a, h2a;
    logic [0:6] h0b, h1b, h2b;
    logic       busy1, done1, busy0, done0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // model state
    int         cyc = 0;
    int         t0 = 0;
    bit         act = 0;
    bit         m_neg = 0;
    int         m_lo = 0;
    int         m_hi = 0;
    logic [0:6] e_h0 = '0;
    logic [0:6] e_h1b = '0;
    logic [0:6] e_h1n = '0;
    logic [0:6] e_h2 = '0;

    always #5 clk = ~clk;

    function automatic logic [0:6] seg(input logic [3:0] v);
        logic [0:6] s;
        case (v)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    assign sev1 = seg(nib1);
    assign sev0 = seg(nib0);

    product_display_sequencer #(
        .BLANK_LEADING(1'b1),
        .SIGN_PATTERN (7'b0000001)
    ) u_blank (
        .CLK    (clk),
        .RST    (rst),
        .LOAD   (load),
        .PRODUCT(prod),
        .NIB    (nib1),
        .SEV_IN (sev1),
        .HEX0   (h0a),
        .HEX1   (h1a),
        .HEX2   (h2a),
        .BUSY   (busy1),
        .DONE   (done1)
    );

    product_display_sequencer #(
        .BLANK_LEADING(1'b0),
        .SIGN_PATTERN (7'b0000001)
    ) u_full (
        .CLK    (clk),
        .RST    (rst),
        .LOAD   (load),
        .PRODUCT(prod),
        .NIB    (nib0),
        .SEV_IN (sev0),
        .HEX0   (h0b),
        .HEX1   (h1b),
        .HEX2   (h2b),
        .BUSY   (busy0),
        .DONE   (done0)
    );

    task automatic check(input string nm, input logic [7:0] a,
                         input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d got %b want %b", nm, cyc, a, e);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, return at negedge
    task automatic step(input bit r, input bit l, input logic [7:0] p);
        int d;
        int sp;
        int mg;
        rst  = r;
        load = l;
        prod = p;
        @(posedge clk);
        cyc++;
        if (r) begin
            act  = 0;
            e_h0 = '0;
            e_h1b = '0;
            e_h1n = '0;
            e_h2 = '0;
        end else begin
            if (l && !(act && (cyc - 1 - t0) < 5)) begin
                act   = 1;
                t0    = cyc - 1;
                sp    = int'($signed(p));
                m_neg = (sp < 0);
                mg    = (sp < 0) ? -sp : sp;
                m_lo  = mg % 16;
                m_hi  = mg / 16;
            end
            if (act) begin
                d = cyc - t0;
                if (d == 3) e_h0 = seg(4'(m_lo));
                if (d == 4) begin
                    e_h1n = seg(4'(m_hi));
                    e_h1b = (m_hi == 0) ? 7'b0000000 : seg(4'(m_hi));
                end
                if (d == 5) e_h2 = m_neg ? 7'b0000001 : 7'b0000000;
            end
        end
        @(negedge clk);
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            int  d;
            bit  eb;
            bit  ed;
            logic [3:0] en;
            d  = cyc - t0;
            eb = act && d >= 1 && d <= 4;
            ed = act && d == 4;
            en = 4'd0;
            if (act && d == 2) en = 4'(m_lo);
            if (act && d == 3) en = 4'(m_hi);
            check("busy_b", 8'(busy1), 8'(eb));
            check("done_b", 8'(done1), 8'(ed));
            check("nib_b", 8'(nib1), 8'(en));
            check("hex0_b", 8'(h0a), 8'(e_h0));
            check("hex1_b", 8'(h1a), 8'(e_h1b));
            check("hex2_b", 8'(h2a), 8'(e_h2));
            check("busy_f", 8'(busy0), 8'(eb));
            check("done_f", 8'(done0), 8'(ed));
            check("nib_f", 8'(nib0), 8'(en));
            check("hex0_f", 8'(h0b), 8'(e_h0));
            check("hex1_f", 8'(h1b), 8'(e_h1n));
            check("hex2_f", 8'(h2b), 8'(e_h2));
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00);
    endtask

    initial begin
        @(negedge clk);
        step(1, 0, 8'h00);
        chk_en = 1;
        step(1, 0, 8'h00);
        idle(10);
        check("lit_rst_hex0", 8'(h0a), 8'h00);
        check("lit_rst_busy", 8'(busy1), 8'h00);

        // +42: NIB sequence, DONE timing, final digits
        step(0, 1, 8'h2A);
        idle(1);
        check("lit_nib_lo", 8'(nib1), 8'h0A);
        idle(1);
        check("lit_nib_hi", 8'(nib1), 8'h02);
        idle(1);
        check("lit_done", 8'(done1), 8'h01);
        idle(1);
        check("lit_busy_fall", 8'(busy1), 8'h00);
        check("lit_42_h0", 8'(h0a), 8'(7'b1110111));
        check("lit_42_h1", 8'(h1a), 8'(7'b1101101));
        check("lit_42_h2", 8'(h2a), 8'(7'b0000000));

        // -15 with and without leading blank
        step(0, 1, 8'hF1);
        idle(6);
        check("lit_m15_h0", 8'(h0a), 8'(7'b1000111));
        check("lit_m15_h1b", 8'(h1a), 8'(7'b0000000));
        check("lit_m15_h1f", 8'(h1b), 8'(7'b1111110));
        check("lit_m15_h2", 8'(h2a), 8'(7'b0000001));

        // -128 and zero
        step(0, 1, 8'h80);
        idle(6);
        check("lit_m128_h0", 8'(h0a), 8'(7'b1111110));
        check("lit_m128_h1", 8'(h1a), 8'(7'b1111111));
        check("lit_m128_h2", 8'(h2a), 8'(7'b0000001));
        step(0, 1, 8'h00);
        idle(6);
        check("lit_zero_h0", 8'(h0a), 8'(7'b1111110));
        check("lit_zero_h1", 8'(h1a), 8'(7'b0000000));
        check("lit_zero_h2", 8'(h2a), 8'(7'b0000000));

        // LOAD while busy and in the DONE cycle are ignored
        step(0, 1, 8'h2A);
        step(0, 1, 8'hF1);
        idle(2);
        check("lit_done_cyc", 8'(done1), 8'h01);
        step(0, 1, 8'hF1);
        idle(3);
        check("lit_ovl_h0", 8'(h0a), 8'(7'b1110111));
        check("lit_ovl_h2", 8'(h2a), 8'(7'b0000000));

        // Reset during DEC_HI aborts
        step(0, 1, 8'hF1);
        idle(2);
        step(1, 0, 8'h00);
        check("lit_abort_h0", 8'(h0a), 8'h00);
        check("lit_abort_busy", 8'(busy1), 8'h00);
        idle(2);
        step(0, 1, 8'h2A);
        idle(6);
        check("lit_after_h1", 8'(h1a), 8'(7'b1101101));

        // Randomised traffic with corner-value bias
        for (int i = 0; i < 600; i++) begin
            logic [7:0] p;
            bit r;
            bit l;
            p = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: p = 8'h80;
                    1: p = 8'h00;
                    2: p = 8'hFF;
                    3: p = 8'h7F;
                    default: p = 8'h0F;
                endcase
            end
            r = ($urandom_range(0, 59) == 0);
            l = ($urandom_range(0, 2) == 0);
            step(r, l, p);
        end
        idle(8);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
